sync_fifo_param: RTL and testbench

- Single-clock, parametrised FIFO; successor to the dual-clock FIFO in the stack area, for blocks that share one clock domain.
- Adds configurable width and depth, selectable read mode (standard registered read or first-word-fall-through), an occupancy count, and programmable almost-full/almost-empty flags.
- Sits between producer and consumer pipeline stages inside one clock domain.

---
 rtl/sync_fifo_param_if.sv | 40 ++++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bus of the single-clock FIFO.
// Producer side: wr_data, wr_en in; full, almost_full back.
// Consumer side: rd_en in; rd_data, rd_valid, empty, almost_empty, count back.
// With SYNC_FIFO_ERR_FLAGS_EN defined, the sticky overflow/underflow flags are added.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
    modport master (
        output wr_data, wr_en, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_data, wr_en, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty, count, overflow, underflow
    );
`else
    modport master (
        output wr_data, wr_en, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count
    );
    modport slave (
        input  wr_data, wr_en, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty, count
    );
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with standard or first-word-fall-through read,
// registered occupancy count and programmable almost-full/almost-empty flags.
// Ports: clk (rising edge), rst_n (synchronous, active low), bus (sync_fifo_param_if.slave:
// wr_data/wr_en/full/almost_full on the write side, rd_en/rd_data/rd_valid/empty/almost_empty/count
// on the read side).
// Optional: define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags to the bus.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Acceptance uses only the registered flags, so a read never frees space for a write
    // in the same cycle and a write never feeds a read in the same cycle.
    assign wr_acc  = bus.wr_en && !full_q;
    assign rd_acc  = bus.rd_en && !empty_q;
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        count_d  = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
        // Same slot with opposite wrap bits means the writer is a full lap ahead.
        full_d   = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
        empty_d  = wr_ptr_d == rd_ptr_d;
        af_d     = count_d >= AF_L;
        ae_d     = count_d <= AE_L;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while empty so the
            // unreset storage never leaks onto rd_data.
            assign bus.rd_data  = empty_q ? '0 : mem_q[rd_addr];
            assign bus.rd_valid = !empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_acc ? mem_q[rd_addr] : rd_data_q;
                    rd_valid_q <= rd_acc;
                end
            end
            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q || (bus.wr_en && full_q);
            underflow_q <= underflow_q || (bus.rd_en && empty_q);
        end
    end
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: checks a standard-mode and a FWFT-mode sync_fifo_param against a queue model.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b0 ();
    sync_fifo_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) b1 ();

    sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] exp_rd0 = '0;
    logic        exp_v0 = 1'b0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] d;
        logic [4:0]  cnt;
        logic        v;
        logic [15:0] rdat;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input int k);
        int n;
        logic [4:0] c;
        logic f, e, af, ae, v;
        logic [15:0] d;
        n = (k == 0) ? q0.size() : q1.size();
        if (k == 0) {c, f, e, af, ae, v, d} = {b0.count, b0.full, b0.empty, b0.almost_full,
                                               b0.almost_empty, b0.rd_valid, b0.rd_data};
        else        {c, f, e, af, ae, v, d} = {b1.count, b1.full, b1.empty, b1.almost_full,
                                               b1.almost_empty, b1.rd_valid, b1.rd_data};
        chk($sformatf("count%0d", k), 32'(c), 32'(n));
        chk($sformatf("full%0d", k), 32'(f), 32'(n == 16));
        chk($sformatf("empty%0d", k), 32'(e), 32'(n == 0));
        chk($sformatf("almost_full%0d", k), 32'(af), 32'(n >= 14));
        chk($sformatf("almost_empty%0d", k), 32'(ae), 32'(n <= 2));
        if (k == 0) begin
            chk("rd_valid0", 32'(v), 32'(exp_v0));
            chk("rd_data0", 32'(d), 32'(exp_rd0));
        end else begin
            chk("rd_valid1", 32'(v), 32'(n != 0));
            if (n != 0) chk("rd_data1", 32'(d), 32'(q1[0]));
        end
    endtask

    // One clock on DUT k: drive, update the model from pre-edge occupancy, compare at negedge.
    task automatic step(input int k, input logic wr, input logic [15:0] d, input logic rd);
        int n;
        logic [15:0] junk;
        if (k == 0) begin b0.wr_en = wr; b0.wr_data = d; b0.rd_en = rd; end
        else        begin b1.wr_en = wr; b1.wr_data = d; b1.rd_en = rd; end
        @(posedge clk);
        n = (k == 0) ? q0.size() : q1.size();
        if (k == 0) begin
            exp_v0 = rd && n != 0;
            if (exp_v0) exp_rd0 = q0.pop_front();
            if (wr && n != 16) q0.push_back(d);
        end else begin
            if (rd && n != 0) junk = q1.pop_front();
            if (wr && n != 16) q1.push_back(d);
        end
        @(negedge clk);
        b0.wr_en = 1'b0; b0.rd_en = 1'b0;
        b1.wr_en = 1'b0; b1.rd_en = 1'b0;
        check_state(k);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        b0.wr_en = 1'b0; b0.rd_en = 1'b0;
        b1.wr_en = 1'b0; b1.rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        exp_v0 = 1'b0;
        exp_rd0 = '0;
        check_state(0);
        check_state(1);
        chk("rst_rd_data1", 32'(b1.rd_data), 32'h0);
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 16'h00A1, 5'd1, 1'b0, 16'h0000};
        tv[1] = '{1'b1, 1'b0, 16'h00A2, 5'd2, 1'b0, 16'h0000};
        tv[2] = '{1'b1, 1'b1, 16'h00A3, 5'd2, 1'b1, 16'h00A1};
        tv[3] = '{1'b1, 1'b0, 16'h00A4, 5'd3, 1'b0, 16'h00A1};
        tv[4] = '{1'b0, 1'b1, 16'h0000, 5'd2, 1'b1, 16'h00A2};
        tv[5] = '{1'b0, 1'b1, 16'h0000, 5'd1, 1'b1, 16'h00A3};
        tv[6] = '{1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 16'h00A4};
        tv[7] = '{1'b0, 1'b1, 16'h0000, 5'd0, 1'b0, 16'h00A4};
        tv[8] = '{1'b1, 1'b1, 16'h00B0, 5'd1, 1'b0, 16'h00A4};
        tv[9] = '{1'b0, 1'b1, 16'h0000, 5'd0, 1'b1, 16'h00B0};
        b0.wr_en = 1'b0; b0.rd_en = 1'b0; b0.wr_data = '0;
        b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.wr_data = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(0, tv[i].wr, tv[i].d, tv[i].rd);
            chk($sformatf("tv%0d_count", i), 32'(b0.count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d_valid", i), 32'(b0.rd_valid), 32'(tv[i].v));
            chk($sformatf("tv%0d_data", i), 32'(b0.rd_data), 32'(tv[i].rdat));
        end

        do_reset();
        step(0, 1'b1, 16'h1234, 1'b0);
        step(0, 1'b0, 16'h0, 1'b0);
        step(0, 1'b0, 16'h0, 1'b0);
        step(0, 1'b0, 16'h0, 1'b1);
        chk("single_valid", 32'(b0.rd_valid), 32'h1);
        chk("single_data", 32'(b0.rd_data), 32'h1234);
        chk("single_empty", 32'(b0.empty), 32'h1);

        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 16'(i), 1'b0);
            if (i == 12) chk("af_before14", 32'(b0.almost_full), 32'h0);
            if (i == 13) chk("af_at14", 32'(b0.almost_full), 32'h1);
        end
        chk("fill_full", 32'(b0.full), 32'h1);
        chk("fill_count", 32'(b0.count), 32'd16);
        step(0, 1'b1, 16'hDEAD, 1'b0);
        chk("ovf_ignored_count", 32'(b0.count), 32'd16);
        step(0, 1'b1, 16'hBEEF, 1'b1);
        chk("full_rw_count", 32'(b0.count), 32'd15);
        chk("full_rw_data", 32'(b0.rd_data), 32'h0000);
        for (int i = 0; i < 15; i++) step(0, 1'b0, 16'h0, 1'b1);
        chk("drain_last", 32'(b0.rd_data), 32'h000F);
        chk("drain_empty", 32'(b0.empty), 32'h1);

        for (int i = 0; i < 10; i++) step(0, 1'b1, 16'(16'h0200 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) step(0, 1'b1, 16'(16'h0300 + i), 1'b0);
        for (int i = 0; i < 12; i++) step(0, 1'b0, 16'h0, 1'b1);
        chk("wrap_last", 32'(b0.rd_data), 32'h030B);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 16'(16'h0400 + i), 1'b0);
        step(0, 1'b1, 16'h0455, 1'b1);
        chk("simul_count", 32'(b0.count), 32'd5);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 8; i++) step(0, 1'b1, 16'(16'h0100 + i), 1'b0);
        step(0, 1'b0, 16'h0, 1'b1);
        chk("mid_count", 32'(b0.count), 32'd7);
        do_reset();
        chk("rst_count", 32'(b0.count), 32'd0);
        step(0, 1'b1, 16'h0BEE, 1'b0);
        step(0, 1'b0, 16'h0, 1'b1);
        chk("post_rst_data", 32'(b0.rd_data), 32'h0BEE);

        step(1, 1'b1, 16'hA5A5, 1'b0);
        chk("fwft_valid", 32'(b1.rd_valid), 32'h1);
        chk("fwft_data", 32'(b1.rd_data), 32'hA5A5);
        step(1, 1'b0, 16'h0, 1'b1);
        chk("fwft_empty", 32'(b1.empty), 32'h1);
        for (int i = 0; i < 4; i++) step(1, 1'b1, 16'(16'h0500 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 400; i++)
            step(i % 2, 1'($urandom_range(0, 99) < ((i % 160) < 80 ? 75 : 25)),
                 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        do_reset();
        chk("ovf_rst", 32'(b0.overflow), 32'h0);
        chk("unf_rst", 32'(b0.underflow), 32'h0);
        step(0, 1'b0, 16'h0, 1'b1);
        chk("unf_set", 32'(b0.underflow), 32'h1);
        step(0, 1'b0, 16'h0, 1'b0);
        chk("unf_sticky", 32'(b0.underflow), 32'h1);
        for (int i = 0; i < 16; i++) step(0, 1'b1, 16'(i), 1'b0);
        chk("ovf_clear_at_fill", 32'(b0.overflow), 32'h0);
        step(0, 1'b1, 16'h0, 1'b0);
        chk("ovf_set", 32'(b0.overflow), 32'h1);
        do_reset();
        chk("ovf_cleared", 32'(b0.overflow), 32'h0);
        chk("unf_cleared", 32'(b0.underflow), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
